inference_controller: RTL and testbench
=======================================

# inference_controller

Sequences one logistic-regression inference over a stored 28×28 image. Each `image_loaded` pulse from the image loader (taken only while `weights_loaded`) starts a pass over 10 classes. For each class the block reads the bias, then runs 784 pixel×weight multiply-accumulates out of the image and weight RAMs. It reports the arg-max class and its score, and drives `busy` so upstream logic can hold off new image writes.

## Interface
- `IMG_SIZE`, 784, pixels per image
- `NUM_CLASSES`, 10, output classes
- `ACC_W`, 32, accumulator / bias / score width, signed
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `weights_loaded`  in  1  level; weight and bias RAMs valid
- `image_loaded`  in  1  1-cycle pulse; image RAM holds a complete image
- `img_rd_addr`  out  10  image RAM read address
- `img_rd_data`  in  8  unsigned pixel, valid 1 cycle after address
- `w_rd_addr`  out  13  weight RAM address = class·784 + pixel
- `w_rd_data`  in  8  signed weight, 1-cycle read latency
- `bias_rd_addr`  out  4  bias RAM address = class
- `bias_rd_data`  in  ACC_W  signed bias, 1-cycle read latency
- `busy`  out  1  high from the first cycle after start until `result_valid`
- `result_valid`  out  1  1-cycle pulse; result outputs updated
- `predicted_digit`  out  4  arg-max class index
- `max_score`  out  ACC_W  signed score of `predicted_digit`

## Operation
- Reset values: all outputs 0; FSM in IDLE; class and pixel counters 0; accumulator 0; best-score register 0.
- IDLE: a start occurs when `image_loaded` && `weights_loaded`; the FSM then enters LOAD_BIAS with class=0. `image_loaded` is ignored in every other state and whenever `weights_loaded`=0.
- LOAD_BIAS (1 cycle): drives `bias_rd_addr`=class, then moves to MAC with pixel=0.
- MAC (784 cycles): drives `img_rd_addr`=pixel and `w_rd_addr`=class·784+pixel, and increments pixel.
  - On the first MAC cycle, acc ← `bias_rd_data`.
  - On each later MAC cycle and on the DRAIN cycle, acc ← acc + product of the previous cycle's read data.
  - After pixel 783 the FSM moves to DRAIN.
- DRAIN (1 cycle): accumulates the pixel-783 product.
- COMPARE (1 cycle):
  - If class=0, or acc > best (signed, strict), then best ← acc and best_idx ← class.
  - If class<9: class increments and the FSM returns to LOAD_BIAS.
  - Otherwise the FSM goes to DONE.
- DONE (1 cycle): `max_score` ← best, `predicted_digit` ← best_idx, `result_valid`=1, `busy`=0, then IDLE.
- Arithmetic:
  - The pixel is zero-extended to 9 bits signed and multiplied by the signed 8-bit weight, giving a 17-bit signed product.
  - The product is sign-extended to ACC_W and added; the sum wraps modulo 2^ACC_W with no saturation.
- Ties: the lowest class index wins, because the compare is strict.
- `weights_loaded` falling while not IDLE aborts the pass to IDLE. No `result_valid` is produced and previous results are held.
- `predicted_digit` and `max_score` hold their value until the next DONE.
- Unused read addresses hold their last value, so there are no glitch requirements.

## Timing
- Let cycle 0 be the cycle in which the start is sampled. Class c occupies cycles 1+787c through 787+787c: LOAD_BIAS, then 784 MAC, then DRAIN, then COMPARE.
- `result_valid` is high in cycle 7871 exactly; `busy` is high in cycles 1–7870.
- Start-to-start minimum is 7872 cycles, since the FSM must be back in IDLE.
- All outputs are registered; there are no combinational paths from input to output.
- An `rst` assertion at any point clears state and outputs asynchronously. No partial `result_valid` is emitted.

## Structure
- Shared package `inference_pkg` holds:
  - `IMG_SIZE`, `NUM_CLASSES`, pixel/weight/accumulator widths
  - FSM state encoding: IDLE, LOAD_BIAS, MAC, DRAIN, COMPARE, DONE
  - `CYCLES_PER_CLASS`=787
- One sub-module, `mac_unit`: a signed multiply-accumulate with `load` (acc ← bias) and `en` (acc += a·b) controls and a 1-register accumulator.
- The controller instantiates `mac_unit` and owns the FSM, counters and arg-max logic.

## Test plan
- All pixels=1; every weight of class c = c; all biases 0; start at cycle 0 → `result_valid` in cycle 7871 only, `predicted_digit`=9, `max_score`=7056.
- All weights 0; all biases=5 → `predicted_digit`=0, `max_score`=5 (tie rule).
- Pixels=255; weights=−128 for all classes except class 3 with weights=−1; biases 0 → `predicted_digit`=3, `max_score`=−199920.
- Address monitor over a full pass:
  - `bias_rd_addr`=c at each LOAD_BIAS
  - `img_rd_addr` runs 0..783 per class
  - `w_rd_addr` = c·784+k, reaching 7839 last
  - `busy` high in cycles 1–7870
- `image_loaded` pulsed at cycle 100 mid-pass → ignored, single result at 7871. `image_loaded` with `weights_loaded`=0 → stays IDLE, `busy`=0.
- Reset edge cases:
  - `rst` asserted at cycle 4000 → all outputs 0 before the next clock edge; no `result_valid`; a fresh start after release gives the correct result.
  - `weights_loaded` dropped at cycle 2000 → abort; previous results held.

Source files
------------

// File: rtl/inference_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inference_pkg
// Description : Shared sizes, constants and FSM encoding for the inference
//               controller and its multiply-accumulate unit.
// Revision    : 1.0 - initial release
// ============================================================================
package inference_pkg;

    localparam int IMG_SIZE         = 784;
    localparam int NUM_CLASSES      = 10;
    localparam int PIX_W            = 8;
    localparam int WGT_W            = 8;
    localparam int ACC_W            = 32;
    localparam int PROD_W           = PIX_W + WGT_W + 1;
    localparam int CYCLES_PER_CLASS = IMG_SIZE + 3;

    localparam int IMG_ADDR_W = 10;
    localparam int W_ADDR_W   = 13;
    localparam int CLS_W      = 4;

    localparam logic [IMG_ADDR_W-1:0] LAST_PIXEL = IMG_ADDR_W'(IMG_SIZE - 1);
    localparam logic [CLS_W-1:0]      LAST_CLASS = CLS_W'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_BIAS = 3'd1,
        MAC       = 3'd2,
        DRAIN     = 3'd3,
        COMPARE   = 3'd4,
        DONE      = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : mac_unit
// Description : Signed pixel x weight multiply-accumulate with bias preload.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_unit
    import inference_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] bias,
    input  logic        [PIX_W-1:0] pixel,
    input  logic signed [WGT_W-1:0] weight,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [PROD_W-1:0] w_pix_ext;
    logic signed [PROD_W-1:0] w_wgt_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  r_acc;

    // Pixel is unsigned, so it is zero-extended; the 17-bit product cannot overflow.
    assign w_pix_ext  = {{(PROD_W-PIX_W){1'b0}}, pixel};
    assign w_wgt_ext  = {{(PROD_W-WGT_W){weight[WGT_W-1]}}, weight};
    assign w_prod     = w_pix_ext * w_wgt_ext;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (load) begin
            r_acc <= bias;
        end else if (en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/inference_controller.sv
`default_nettype none
// ============================================================================
// Module      : inference_controller
// Description : Sequences a 10-class logistic-regression pass over a stored
//               image and reports the arg-max class and its score.
// Revision    : 1.0 - initial release
// ============================================================================
module inference_controller
    import inference_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         weights_loaded,
    input  logic                         image_loaded,
    output logic        [IMG_ADDR_W-1:0] img_rd_addr,
    input  logic        [PIX_W-1:0]      img_rd_data,
    output logic        [W_ADDR_W-1:0]   w_rd_addr,
    input  logic signed [WGT_W-1:0]      w_rd_data,
    output logic        [CLS_W-1:0]      bias_rd_addr,
    input  logic signed [ACC_W-1:0]      bias_rd_data,
    output logic                         busy,
    output logic                         result_valid,
    output logic        [CLS_W-1:0]      predicted_digit,
    output logic signed [ACC_W-1:0]      max_score
);

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_start;
    logic                    w_mac_load;
    logic                    w_mac_en;
    logic                    w_take;
    logic signed [ACC_W-1:0] w_acc;

    logic [CLS_W-1:0]        r_class;
    logic [CLS_W-1:0]        r_best_idx;
    logic [IMG_ADDR_W-1:0]   r_pixel;
    logic [W_ADDR_W-1:0]     r_w_addr;
    logic signed [ACC_W-1:0] r_best;

    logic                    r_busy;
    logic                    r_result_valid;
    logic [CLS_W-1:0]        r_pred;
    logic signed [ACC_W-1:0] r_max;

    mac_unit u_mac (
        .clk    (clk),
        .rst    (rst),
        .load   (w_mac_load),
        .en     (w_mac_en),
        .bias   (bias_rd_data),
        .pixel  (img_rd_data),
        .weight (w_rd_data),
        .acc    (w_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Read data lags the address by a cycle, so the MAC works one step behind.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_mac_load = 1'b0;
        w_mac_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (image_loaded && weights_loaded) begin
                    w_start = 1'b1;
                    w_next  = LOAD_BIAS;
                end
            end
            LOAD_BIAS: w_next = MAC;
            MAC: begin
                w_mac_load = (r_pixel == '0);
                w_mac_en   = (r_pixel != '0);
                if (r_pixel == LAST_PIXEL) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                w_mac_en = 1'b1;
                w_next   = COMPARE;
            end
            COMPARE: w_next = (r_class == LAST_CLASS) ? DONE : LOAD_BIAS;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if ((r_state != IDLE) && !weights_loaded) begin
            w_next = IDLE;
        end
    end

    assign w_take = (r_class == '0) || (w_acc > r_best);

    // The weight address simply free-runs: class c ends at c*784+783, the next starts at (c+1)*784.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_class    <= '0;
            r_pixel    <= '0;
            r_w_addr   <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_class  <= '0;
                        r_pixel  <= '0;
                        r_w_addr <= '0;
                    end
                end
                MAC: begin
                    r_pixel  <= (r_pixel == LAST_PIXEL) ? '0 : r_pixel + IMG_ADDR_W'(1);
                    r_w_addr <= r_w_addr + W_ADDR_W'(1);
                end
                COMPARE: begin
                    if (w_take) begin
                        r_best     <= w_acc;
                        r_best_idx <= r_class;
                    end
                    if (r_class != LAST_CLASS) begin
                        r_class <= r_class + CLS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_pred         <= '0;
            r_max          <= '0;
        end else begin
            r_busy         <= (w_next != IDLE) && (w_next != DONE);
            r_result_valid <= (w_next == DONE);
            if (w_next == DONE) begin
                r_pred <= w_take ? r_class : r_best_idx;
                r_max  <= w_take ? w_acc : r_best;
            end
        end
    end

    assign img_rd_addr     = r_pixel;
    assign w_rd_addr       = r_w_addr;
    assign bias_rd_addr    = r_class;
    assign busy            = r_busy;
    assign result_valid    = r_result_valid;
    assign predicted_digit = r_pred;
    assign max_score       = r_max;

endmodule
`default_nettype wire

// File: tb/tb_inference_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_inference_controller
// Description : Self-checking bench; RAM models plus a cycle-phase reference
//               model of inference_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inference_controller;
    import inference_pkg::*;

    localparam int NPIX     = IMG_SIZE;
    localparam int NCLS     = NUM_CLASSES;
    localparam int CPC      = CYCLES_PER_CLASS;
    localparam int PASS_CYC = NCLS * CPC + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               weights_loaded = 1'b0;
    logic               image_loaded = 1'b0;
    logic        [9:0]  img_rd_addr;
    logic        [7:0]  img_rd_data;
    logic        [12:0] w_rd_addr;
    logic signed [7:0]  w_rd_data;
    logic        [3:0]  bias_rd_addr;
    logic signed [31:0] bias_rd_data;
    logic               busy;
    logic               result_valid;
    logic        [3:0]  predicted_digit;
    logic signed [31:0] max_score;

    inference_controller dut (
        .clk             (clk),
        .rst             (rst),
        .weights_loaded  (weights_loaded),
        .image_loaded    (image_loaded),
        .img_rd_addr     (img_rd_addr),
        .img_rd_data     (img_rd_data),
        .w_rd_addr       (w_rd_addr),
        .w_rd_data       (w_rd_data),
        .bias_rd_addr    (bias_rd_addr),
        .bias_rd_data    (bias_rd_data),
        .busy            (busy),
        .result_valid    (result_valid),
        .predicted_digit (predicted_digit),
        .max_score       (max_score)
    );

    always #5 clk = ~clk;

    logic        [7:0]  img_mem  [1024];
    logic signed [7:0]  w_mem    [8192];
    logic signed [31:0] bias_mem [16];

    always @(posedge clk) begin
        img_rd_data  <= img_mem[img_rd_addr];
        w_rd_data    <= w_mem[w_rd_addr];
        bias_rd_data <= bias_mem[bias_rd_addr];
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: plain integer dot products (int wraps mod 2^32) and a strict arg-max.
    function automatic int class_score(input int c);
        int s = bias_mem[c];
        for (int k = 0; k < NPIX; k++)
            s += int'(img_mem[k]) * int'(w_mem[c*NPIX + k]);
        return s;
    endfunction

    function automatic int best_class();
        int b  = 0;
        int bs = class_score(0);
        for (int c = 1; c < NCLS; c++) begin
            int s = class_score(c);
            if (s > bs) begin
                bs = s;
                b  = c;
            end
        end
        return b;
    endfunction

    // ph = cycles since the start was sampled, -1 when no pass is in flight.
    int         ph = -1;
    logic [3:0] held_pred = '0;
    int         held_max = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph        <= -1;
            held_pred <= '0;
            held_max  <= 0;
        end else if (ph < 0) begin
            if (image_loaded && weights_loaded) ph <= 1;
        end else if (!weights_loaded || ph == PASS_CYC) begin
            ph <= -1;
        end else begin
            ph <= ph + 1;
            if (ph == PASS_CYC - 1) begin
                held_pred <= 4'(best_class());
                held_max  <= class_score(best_class());
            end
        end
    end

    int cls_i;
    int off_i;
    always @(negedge clk) begin
        check("busy", busy, (ph >= 1 && ph <= PASS_CYC - 1) ? 1 : 0);
        check("result_valid", result_valid, (ph == PASS_CYC) ? 1 : 0);
        check("predicted_digit", predicted_digit, held_pred);
        check("max_score", max_score, held_max);
        if (ph >= 1 && ph <= PASS_CYC - 1) begin
            cls_i = (ph - 1) / CPC;
            off_i = (ph - 1) % CPC;
            if (off_i == 0)
                check("bias_rd_addr", bias_rd_addr, cls_i);
            else if (off_i <= NPIX) begin
                check("img_rd_addr", img_rd_addr, off_i - 1);
                check("w_rd_addr", w_rd_addr, cls_i*NPIX + off_i - 1);
            end
        end
    end

    task automatic run_pass(input string tag, input bit mid_pulse);
        int n;
        bit seen;
        image_loaded = 1'b1;
        @(negedge clk);
        image_loaded = 1'b0;
        n    = 1;
        seen = 1'b0;
        while (!seen && n <= PASS_CYC + 20) begin
            if (result_valid) seen = 1'b1;
            else begin
                if (mid_pulse && n == 100) image_loaded = 1'b1;
                else if (mid_pulse && n == 101) image_loaded = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        check({tag, "_valid_cycle"}, seen ? n : -1, PASS_CYC);
        @(negedge clk);
    endtask

    task automatic fill_random(input bit wrap);
        for (int k = 0; k < NPIX; k++)
            img_mem[k] = wrap ? 8'd255 : 8'($urandom_range(0, 255));
        for (int i = 0; i < NCLS*NPIX; i++)
            w_mem[i] = wrap ? 8'($urandom_range(0, 127)) : 8'($urandom);
        for (int c = 0; c < NCLS; c++) begin
            int b;
            if (wrap) b = (c % 2 == 0) ? (32'h7FF0_0000 + int'($urandom_range(0, 1000))) : int'($urandom);
            else      b = int'($urandom_range(0, 2000000)) - 1000000;
            bias_mem[c] = b;
        end
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (result_valid) cnt++;
        end
    endtask

    initial begin
        int n;
        int vcnt;
        for (int i = 0; i < 1024; i++) img_mem[i] = '0;
        for (int i = 0; i < 8192; i++) w_mem[i] = '0;
        for (int i = 0; i < 16; i++) bias_mem[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_pred", predicted_digit, 0);
        check("rst_max", max_score, 0);
        check("rst_img_addr", img_rd_addr, 0);
        check("rst_w_addr", w_rd_addr, 0);
        rst = 1'b0;
        weights_loaded = 1'b1;
        @(negedge clk);

        // Ones image, class c weights = c, zero bias; stray start pulse at cycle 100.
        for (int k = 0; k < NPIX; k++) img_mem[k] = 8'd1;
        for (int c = 0; c < NCLS; c++)
            for (int k = 0; k < NPIX; k++) w_mem[c*NPIX + k] = 8'(c);
        run_pass("t1", 1'b1);
        check("t1_pred", predicted_digit, 9);
        check("t1_max", max_score, 7056);

        // Back-to-back start at the earliest legal cycle; all-equal scores test the tie rule.
        for (int i = 0; i < NCLS*NPIX; i++) w_mem[i] = '0;
        for (int c = 0; c < NCLS; c++) bias_mem[c] = 32'sd5;
        run_pass("t2", 1'b0);
        check("t2_pred", predicted_digit, 0);
        check("t2_max", max_score, 5);

        for (int k = 0; k < NPIX; k++) img_mem[k] = 8'd255;
        for (int c = 0; c < NCLS; c++) begin
            bias_mem[c] = '0;
            for (int k = 0; k < NPIX; k++) w_mem[c*NPIX + k] = (c == 3) ? -8'sd1 : -8'sd128;
        end
        run_pass("t3", 1'b0);
        check("t3_pred", predicted_digit, 3);
        check("t3_max", max_score, -199920);

        fill_random(1'b0);
        run_pass("t4", 1'b0);
        fill_random(1'b1);
        run_pass("t5", 1'b0);

        // Abort by dropping weights_loaded at cycle 2000; old result must hold.
        fill_random(1'b0);
        image_loaded = 1'b1;
        @(negedge clk);
        image_loaded = 1'b0;
        n = 1;
        while (n < 2000) begin
            @(negedge clk);
            n++;
        end
        weights_loaded = 1'b0;
        count_valid(PASS_CYC - 2000 + 50, vcnt);
        check("abort_no_valid", vcnt, 0);
        check("abort_busy", busy, 0);

        // Start request with weights not loaded is ignored.
        image_loaded = 1'b1;
        @(negedge clk);
        image_loaded = 1'b0;
        count_valid(10, vcnt);
        check("nowl_busy", busy, 0);
        check("nowl_no_valid", vcnt, 0);
        weights_loaded = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-pass at cycle 4000, then a fresh pass.
        image_loaded = 1'b1;
        @(negedge clk);
        image_loaded = 1'b0;
        n = 1;
        while (n < 4000) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", result_valid, 0);
        check("arst_pred", predicted_digit, 0);
        check("arst_max", max_score, 0);
        check("arst_img_addr", img_rd_addr, 0);
        check("arst_w_addr", w_rd_addr, 0);
        check("arst_bias_addr", bias_rd_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_valid(10, vcnt);
        check("arst_no_valid", vcnt, 0);
        fill_random(1'b0);
        run_pass("t7", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
